// File: rtl/axis_width_upsizer.sv
// ---------------------------------------------------------------------------
// axis_width_upsizer
//
// Packs RATIO consecutive narrow AXI-stream beats into one wide beat. The
// first accepted narrow beat lands in the least-significant lane. A narrow
// beat carrying tlast closes the word early: the unused upper lanes are
// zero-filled and o_out_lanes reports how many lanes carry data.
//
// The wide output is fully registered. Input ready is derived only from the
// registered output valid and the downstream ready, so no combinational path
// runs from i_axis_in_tvalid to o_axis_in_tready.
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_rst_n            asynchronous active-low reset
//   i_axis_in_tdata    narrow input data (DATA_WIDTH)
//   i_axis_in_tvalid   narrow input valid
//   o_axis_in_tready   narrow input ready (0 while in reset)
//   i_axis_in_tlast    narrow input end-of-packet marker
//   o_axis_out_tdata   wide output data (DATA_WIDTH*RATIO), lane 0 = first beat
//   o_axis_out_tvalid  wide output valid
//   i_axis_out_tready  wide output ready from the consumer
//   o_axis_out_tlast   wide output end-of-packet marker
//   o_out_lanes        number of valid lanes in the wide beat (1..RATIO),
//                      qualified by o_axis_out_tvalid
// ---------------------------------------------------------------------------
module axis_width_upsizer #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 2,
    parameter int LANES_W    = $clog2(RATIO + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_WIDTH-1:0]         i_axis_in_tdata,
    input  logic                          i_axis_in_tvalid,
    output logic                          o_axis_in_tready,
    input  logic                          i_axis_in_tlast,
    output logic [DATA_WIDTH*RATIO-1:0]   o_axis_out_tdata,
    output logic                          o_axis_out_tvalid,
    input  logic                          i_axis_out_tready,
    output logic                          o_axis_out_tlast,
    output logic [LANES_W-1:0]            o_out_lanes
);

    localparam int               CNT_W     = $clog2(RATIO);
    localparam int               ACC_LANES = RATIO - 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]                      r_cnt;
    logic [ACC_LANES-1:0][DATA_WIDTH-1:0]  r_acc;
    logic [RATIO-1:0][DATA_WIDTH-1:0]      r_out_data;
    logic                                  r_out_valid;
    logic                                  r_out_last;
    logic [LANES_W-1:0]                    r_out_lanes;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;
    logic w_at_last_lane;
    logic w_complete;
    logic w_out_hs;

    // The output register can take a new word when it is empty or is being
    // drained in this same cycle; the reset term forces ready low while the
    // block is held in reset.
    assign w_in_ready     = i_rst_n && (!r_out_valid || i_axis_out_tready);
    assign w_accept       = i_axis_in_tvalid && w_in_ready;
    assign w_at_last_lane = (r_cnt == LAST_LANE);
    // tlast always closes the word, even on the top lane, so there is never a
    // separate flush cycle.
    assign w_complete     = w_accept && (w_at_last_lane || i_axis_in_tlast);
    assign w_out_hs       = r_out_valid && i_axis_out_tready;

    // -----------------------------------------------------------------------
    // Per-lane datapath: accumulator write enables and the assembled word
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_word_lane [RATIO];
    logic                  w_acc_we    [ACC_LANES];
    logic [RATIO-1:0][DATA_WIDTH-1:0] w_word;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            if (gi < RATIO - 1) begin : g_acc_lane
                // Lanes below the counter come from the accumulator, the lane
                // at the counter takes the incoming beat, lanes above it are
                // zero so an early-closed word is zero-padded.
                assign w_acc_we[gi] = w_accept && !w_complete &&
                                      (r_cnt == CNT_W'(gi));
                assign w_word_lane[gi] =
                    (r_cnt == CNT_W'(gi)) ? i_axis_in_tdata :
                    (r_cnt >  CNT_W'(gi)) ? r_acc[gi]       :
                                            '0;
            end else begin : g_top_lane
                // The top lane is never stored: it only ever carries the beat
                // that completes a full word.
                assign w_word_lane[gi] = w_at_last_lane ? i_axis_in_tdata : '0;
            end
        end
    endgenerate

    always_comb begin
        w_word = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_word[i] = w_word_lane[i];
        end
    end

    // -----------------------------------------------------------------------
    // Lane counter: advances on every partial accept, wraps only through the
    // completion path so it never passes RATIO-1.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_complete) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator: cleared on completion so a later short word never picks
    // up lanes left over from an earlier one.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (w_complete) begin
            r_acc <= '0;
        end else begin
            for (int i = 0; i < ACC_LANES; i++) begin
                if (w_acc_we[i]) begin
                    r_acc[i] <= i_axis_in_tdata;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output register. A completing accept wins over the output handshake so
    // a word drained and a word loaded on the same edge keep valid high.
    // Data, tlast and lanes are left stale once the word has been taken.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_lanes <= '0;
        end else if (w_complete) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
            r_out_last  <= i_axis_in_tlast;
            r_out_lanes <= LANES_W'(r_cnt) + LANES_W'(1);
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_axis_in_tready  = w_in_ready;
    assign o_axis_out_tdata  = r_out_data;
    assign o_axis_out_tvalid = r_out_valid;
    assign o_axis_out_tlast  = r_out_last;
    assign o_out_lanes       = r_out_lanes;

endmodule

// File: tb/tb_axis_width_upsizer.sv
// ---------------------------------------------------------------------------
// Bench for axis_width_upsizer. Two instances share the clock and reset:
// dut_a packs 2 x 32-bit beats, dut_b packs 4 x 32-bit beats. Drivers push
// each accepted narrow beat into a packet-level reference model that groups
// beats into expected wide words; independent monitors pop and compare on
// every output handshake.
// ---------------------------------------------------------------------------
module tb_axis_width_upsizer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // dut_a: RATIO 2
    logic [31:0]  a_in_data  = '0;
    logic         a_in_valid = 1'b0;
    logic         a_in_last  = 1'b0;
    logic         a_in_ready;
    logic [63:0]  a_out_data;
    logic         a_out_valid;
    logic         a_out_ready = 1'b1;
    logic         a_out_last;
    logic [1:0]   a_out_lanes;

    // dut_b: RATIO 4
    logic [31:0]  b_in_data  = '0;
    logic         b_in_valid = 1'b0;
    logic         b_in_last  = 1'b0;
    logic         b_in_ready;
    logic [127:0] b_out_data;
    logic         b_out_valid;
    logic         b_out_ready = 1'b1;
    logic         b_out_last;
    logic [2:0]   b_out_lanes;

    axis_width_upsizer #(.DATA_WIDTH(32), .RATIO(2)) dut_a (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_axis_in_tdata  (a_in_data),
        .i_axis_in_tvalid (a_in_valid),
        .o_axis_in_tready (a_in_ready),
        .i_axis_in_tlast  (a_in_last),
        .o_axis_out_tdata (a_out_data),
        .o_axis_out_tvalid(a_out_valid),
        .i_axis_out_tready(a_out_ready),
        .o_axis_out_tlast (a_out_last),
        .o_out_lanes      (a_out_lanes)
    );

    axis_width_upsizer #(.DATA_WIDTH(32), .RATIO(4)) dut_b (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_axis_in_tdata  (b_in_data),
        .i_axis_in_tvalid (b_in_valid),
        .o_axis_in_tready (b_in_ready),
        .i_axis_in_tlast  (b_in_last),
        .o_axis_out_tdata (b_out_data),
        .o_axis_out_tvalid(b_out_valid),
        .i_axis_out_tready(b_out_ready),
        .o_axis_out_tlast (b_out_last),
        .o_out_lanes      (b_out_lanes)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        int           lanes;
    } exp_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [31:0] pend_a[$];
    logic [31:0] pend_b[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int           a_hs = 0, b_hs = 0;
    int           a_stalls = 0, b_stalls = 0;
    logic [127:0] a_last_data = '0, b_last_data = '0;
    int           a_last_lanes = 0;
    logic         a_last_tlast = 1'b0;
    bit           b_streaming = 1'b0;
    int           b_rises[$];
    bit           a_sim_win = 1'b0;
    int           a_sim_drops = 0;
    bit           rand_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: a wide word is RATIO beats, or fewer when tlast
    // arrives first; beat k of the word occupies bits [32k +: 32].
    task automatic model_push(input int which, input logic [31:0] d, input logic l);
        exp_t e;
        int   n;
        if (which == 0) pend_a.push_back(d); else pend_b.push_back(d);
        n = (which == 0) ? pend_a.size() : pend_b.size();
        if (l || n == ((which == 0) ? 2 : 4)) begin
            e.data  = '0;
            for (int k = 0; k < n; k++)
                e.data[k*32 +: 32] = (which == 0) ? pend_a[k] : pend_b[k];
            e.last  = l;
            e.lanes = n;
            if (which == 0) begin exp_a.push_back(e); pend_a.delete(); end
            else            begin exp_b.push_back(e); pend_b.delete(); end
        end
    endtask

    // Present one beat, hold it until accepted, return at posedge+1.
    task automatic drive_a(input logic [31:0] d, input logic l);
        int n = 0;
        a_in_data = d; a_in_last = l; a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin n++; a_stalls++; @(negedge clk); end
        if (!a_in_ready) begin
            total++; bad++;
            $display("FAIL drive_a_timeout actual=ready_low required=accept");
            a_in_valid = 1'b0;
        end else model_push(0, d, l);
        @(posedge clk); #1;
    endtask

    task automatic drive_b(input logic [31:0] d, input logic l);
        int n = 0;
        b_in_data = d; b_in_last = l; b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin n++; b_stalls++; @(negedge clk); end
        if (!b_in_ready) begin
            total++; bad++;
            $display("FAIL drive_b_timeout actual=ready_low required=accept");
            b_in_valid = 1'b0;
        end else model_push(1, d, l);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor for dut_a
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (a_out_valid && !a_out_ready && exp_a.size() > 0)
                    chk("a_stalled_word", 128'(a_out_data), exp_a[0].data);
                if (a_sim_win && !a_out_valid) a_sim_drops++;
                if (a_out_valid && a_out_ready) begin
                    a_hs++;
                    if (exp_a.size() == 0) begin
                        total++; bad++;
                        $display("FAIL a_unexpected_word actual=%h required=none", a_out_data);
                    end else begin
                        e = exp_a.pop_front();
                        chk("a_word_data",  128'(a_out_data),  e.data);
                        chk("a_word_last",  128'(a_out_last),  128'(e.last));
                        chk("a_word_lanes", 128'(a_out_lanes), 128'(e.lanes));
                        $display("a word %h lanes=%0d last=%0d", a_out_data, a_out_lanes, a_out_last);
                        a_last_data  = 128'(a_out_data);
                        a_last_lanes = int'(a_out_lanes);
                        a_last_tlast = a_out_last;
                    end
                end
            end
        end
    end

    // Monitor for dut_b
    initial begin
        exp_t e;
        logic prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (b_streaming && b_out_valid && !prev_valid) b_rises.push_back(cyc);
                if (b_out_valid && !b_out_ready && exp_b.size() > 0)
                    chk("b_stalled_word", b_out_data, exp_b[0].data);
                if (b_out_valid && b_out_ready) begin
                    b_hs++;
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected_word actual=%h required=none", b_out_data);
                    end else begin
                        e = exp_b.pop_front();
                        chk("b_word_data",  b_out_data,        e.data);
                        chk("b_word_last",  128'(b_out_last),  128'(e.last));
                        chk("b_word_lanes", 128'(b_out_lanes), 128'(e.lanes));
                        $display("b word %h lanes=%0d last=%0d", b_out_data, b_out_lanes, b_out_last);
                        b_last_data = b_out_data;
                    end
                end
            end
            prev_valid = b_out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_a_valid", 128'(a_out_valid), 128'(0));
        chk("rst_a_data",  128'(a_out_data),  128'(0));
        chk("rst_a_ready", 128'(a_in_ready),  128'(0));
        chk("rst_b_ready", 128'(b_in_ready),  128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", 128'(a_in_ready), 128'(1));
        chk("post_rst_b_ready", 128'(b_in_ready), 128'(1));
        @(posedge clk); #1;

        // ---------------- full word, no backpressure ----------------
        a_last_data = '0;
        drive_a(32'hCAFECABE, 1'b0);
        drive_a(32'hDEADCAFE, 1'b1);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("t1_latency_valid", 128'(a_out_valid), 128'(1));
        @(posedge clk); #1;
        chk("t1_data",  a_last_data,         128'(64'hDEADCAFE_CAFECABE));
        chk("t1_lanes", 128'(a_last_lanes),  128'(2));
        chk("t1_tlast", 128'(a_last_tlast),  128'(1));

        // ---------------- early tlast on lane 0 ----------------
        a_last_data = '0;
        drive_a(32'h12345678, 1'b1);
        a_in_valid = 1'b0;
        idle_cycles(1);
        chk("t2_data",  a_last_data,        128'(64'h00000000_12345678));
        chk("t2_lanes", 128'(a_last_lanes), 128'(1));
        chk("t2_tlast", 128'(a_last_tlast), 128'(1));

        // ---------------- backpressure ----------------
        a_out_ready = 1'b0;
        drive_a(32'h11111111, 1'b0);
        drive_a(32'h22222222, 1'b0);
        a_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_in_ready_low", 128'(a_in_ready),  128'(0));
            chk("t3_valid_held",   128'(a_out_valid), 128'(1));
            chk("t3_data_held",    128'(a_out_data),  128'(64'h22222222_11111111));
        end
        @(posedge clk); #1;
        hs0 = a_hs;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        chk("t3_one_handshake", 128'(a_hs - hs0), 128'(1));
        chk("t3_in_ready_back", 128'(a_in_ready), 128'(1));
        chk("t3_valid_dropped", 128'(a_out_valid), 128'(0));
        @(posedge clk); #1;
        a_out_ready = 1'b1;

        // ---------------- streaming, RATIO 4 ----------------
        b_stalls = 0;
        b_rises.delete();
        b_streaming = 1'b1;
        for (int i = 1; i <= 16; i++) drive_b(32'(i), 1'b0);
        b_in_valid = 1'b0;
        idle_cycles(3);
        b_streaming = 1'b0;
        chk("t4_no_ready_drop", 128'(b_stalls), 128'(0));
        chk("t4_word_count",    128'(b_rises.size()), 128'(4));
        for (int i = 1; i < b_rises.size(); i++)
            chk("t4_rise_spacing", 128'(b_rises[i] - b_rises[i-1]), 128'(4));
        chk("t4_last_word", b_last_data,
            128'h00000010_0000000F_0000000E_0000000D);

        // ---------------- reset mid-word ----------------
        drive_a(32'hBAD0BAD0, 1'b0);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        pend_a.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_rst_valid", 128'(a_out_valid), 128'(0));
            chk("t5_rst_data",  128'(a_out_data),  128'(0));
            chk("t5_rst_last",  128'(a_out_last),  128'(0));
            chk("t5_rst_lanes", 128'(a_out_lanes), 128'(0));
            chk("t5_rst_ready", 128'(a_in_ready),  128'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_last_data = '0;
        drive_a(32'hAAAA0001, 1'b0);
        drive_a(32'hBBBB0002, 1'b0);
        a_in_valid = 1'b0;
        idle_cycles(1);
        chk("t5_fresh_word",  a_last_data,        128'(64'hBBBB0002_AAAA0001));
        chk("t5_fresh_lanes", 128'(a_last_lanes), 128'(2));

        // ---------------- handshake and completion on one edge ----------------
        hs0 = a_hs;
        a_sim_drops = 0;
        drive_a(32'h00000A01, 1'b1);
        a_sim_win = 1'b1;
        drive_a(32'h00000A02, 1'b1);
        drive_a(32'h00000A03, 1'b1);
        drive_a(32'h00000A04, 1'b1);
        a_in_valid = 1'b0;
        @(negedge clk);
        a_sim_win = 1'b0;
        idle_cycles(2);
        chk("t6_valid_stays_high", 128'(a_sim_drops), 128'(0));
        chk("t6_word_count",       128'(a_hs - hs0),  128'(4));
        chk("t6_last_word",        a_last_data,       128'(64'h00000000_00000A04));

        // ---------------- randomized traffic with random backpressure ----------------
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 150; i++) begin
                            a_in_valid = 1'b0;
                            idle_cycles($urandom_range(0, 2));
                            drive_a($urandom, ($urandom % 5) == 0);
                        end
                        drive_a($urandom, 1'b1);
                        a_in_valid = 1'b0;
                    end
                    begin
                        for (int i = 0; i < 150; i++) begin
                            b_in_valid = 1'b0;
                            idle_cycles($urandom_range(0, 2));
                            drive_b($urandom, ($urandom % 7) == 0);
                        end
                        drive_b($urandom, 1'b1);
                        b_in_valid = 1'b0;
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    a_out_ready = ($urandom % 4) != 0;
                    b_out_ready = ($urandom % 4) != 0;
                    idle_cycles(1);
                end
            end
        join
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) idle_cycles(1);
        chk("drain_a_empty", 128'(exp_a.size()), 128'(0));
        chk("drain_b_empty", 128'(exp_b.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
